// File: rtl/ofs_axi_fim_clk_pkg.sv
// AXI FIM clock-domain constants shared by blocks on the AXI_FIM_CLK domain.
package ofs_axi_fim_clk_pkg;
    localparam int unsigned AXI_FIM_CLK_HZ = 400000000;
endpackage

// File: rtl/ofs_axi_fim_tmo_pkg.sv
// Types and constants for the AXI FIM stall-timeout monitor.
package ofs_axi_fim_tmo_pkg;
    import ofs_axi_fim_clk_pkg::*;

    localparam int unsigned US_DIV = AXI_FIM_CLK_HZ / 1000000;

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        TMO
    } t_tmo_state;
endpackage

// File: rtl/ofs_axi_fim_stall_timeout_mon_if.sv
// Per-channel valid/ready bundle observed by the stall-timeout monitor.
interface ofs_axi_fim_stall_timeout_mon_if #(
    parameter int unsigned NUM_CH = 5
) ();
    logic [NUM_CH-1:0] valid;
    logic [NUM_CH-1:0] ready;

    modport master (output valid, input  ready);
    modport slave  (input  valid, output ready);
    modport mon    (input  valid, input  ready);
endinterface

// File: rtl/ofs_axi_fim_us_tick.sv
// Free-running prescaler: one-cycle registered pulse every CLK_HZ/1e6 cycles.
module ofs_axi_fim_us_tick #(
    parameter int unsigned CLK_HZ = ofs_axi_fim_clk_pkg::AXI_FIM_CLK_HZ
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_us_tick
);
    localparam int unsigned DIV = CLK_HZ / 1000000;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if ((CLK_HZ % 1000000) != 0 || DIV == 0) begin : g_bad_clk
            $error("ofs_axi_fim_us_tick: CLK_HZ must be a non-zero multiple of 1 MHz");
        end
    endgenerate

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        tick_d = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign o_us_tick = tick_q;
endmodule

// File: rtl/ofs_axi_fim_stall_timeout_mon.sv
// Observes valid/ready channels and flags any held in valid-without-ready
// longer than a programmable number of microseconds.
module ofs_axi_fim_stall_timeout_mon
    import ofs_axi_fim_tmo_pkg::*;
#(
    parameter int unsigned CLK_HZ = ofs_axi_fim_clk_pkg::AXI_FIM_CLK_HZ,
    parameter int unsigned NUM_CH = 5,
    parameter int unsigned TMO_W  = 16,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_enable,
    input  logic [TMO_W-1:0]               i_timeout_us,
    ofs_axi_fim_stall_timeout_mon_if.mon   vr,
    input  logic                           i_clear,
    output logic                           o_us_tick,
    output logic [NUM_CH-1:0]              o_tmo_pulse,
    output logic [NUM_CH-1:0]              o_tmo_sticky,
    output logic                           o_first_valid,
    output logic [CH_W-1:0]                o_first_ch
);
    generate
        if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
            $error("ofs_axi_fim_stall_timeout_mon: NUM_CH must be 1..32");
        end
    endgenerate

    logic              us_tick;
    logic [NUM_CH-1:0] enter_tmo;

    ofs_axi_fim_us_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_us_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .o_us_tick (us_tick)
    );

    assign o_us_tick = us_tick;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        t_tmo_state       state_q, state_d;
        logic [TMO_W-1:0] cnt_q, cnt_d;
        logic [TMO_W-1:0] cnt_inc;
        logic             limit_hit;

        assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + TMO_W'(1);
        // Compare one bit wider so the saturated count still reaches any limit.
        assign limit_hit = ({1'b0, cnt_q} + (TMO_W + 1)'(1)) >= {1'b0, i_timeout_us};

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                IDLE: begin
                    if (i_enable && vr.valid[g] && !vr.ready[g] && (i_timeout_us != '0)) begin
                        state_d = STALL;
                        cnt_d   = '0;
                    end
                end
                STALL: begin
                    if (!i_enable || (i_timeout_us == '0) || vr.ready[g] || !vr.valid[g]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (us_tick) begin
                        cnt_d = cnt_inc;
                        if (limit_hit) begin
                            state_d = TMO;
                        end
                    end
                end
                TMO: begin
                    if (!i_enable || vr.ready[g] || !vr.valid[g]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign enter_tmo[g] = (state_q == STALL) && (state_d == TMO);
    end

    logic [CH_W-1:0]   low_idx;
    logic [NUM_CH-1:0] pulse_q, pulse_d;
    logic [NUM_CH-1:0] sticky_q, sticky_d;
    logic              fv_q, fv_d;
    logic [CH_W-1:0]   fch_q, fch_d;

    always_comb begin
        logic found;
        found   = 1'b0;
        low_idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (enter_tmo[i] && !found) begin
                low_idx = CH_W'(i);
                found   = 1'b1;
            end
        end
    end

    // A timeout entry coinciding with i_clear overrides the clear.
    always_comb begin
        pulse_d  = enter_tmo;
        sticky_d = (i_clear ? '0 : sticky_q) | enter_tmo;
        fv_d     = fv_q & ~i_clear;
        fch_d    = i_clear ? '0 : fch_q;
        if ((!fv_q || i_clear) && (enter_tmo != '0)) begin
            fv_d  = 1'b1;
            fch_d = low_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q  <= '0;
            sticky_q <= '0;
            fv_q     <= 1'b0;
            fch_q    <= '0;
        end else begin
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            fv_q     <= fv_d;
            fch_q    <= fch_d;
        end
    end

    assign o_tmo_pulse   = pulse_q;
    assign o_tmo_sticky  = sticky_q;
    assign o_first_valid = fv_q;
    assign o_first_ch    = fch_q;
endmodule
